// File: rtl/strm2ldpc_seg_if.sv
// strm2ldpc_seg_if: stream-in / encoder-out bus between framer, segmenter and LDPC encoder
interface strm2ldpc_seg_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MODE_W     = 2
);
   logic [DATA_WIDTH-1:0] i_din;
   logic                  i_valid;
   logic                  i_ldpc_ready;
   logic [DATA_WIDTH-1:0] o_dout;
   logic                  o_valid;
   logic                  o_last;
   logic                  o_ldpc_start;
   logic [MODE_W-1:0]     o_ldpc_mode;
   modport master (
      output i_din, i_valid, i_ldpc_ready,
      input  o_dout, o_valid, o_last, o_ldpc_start, o_ldpc_mode
   );
   modport slave (
      input  i_din, i_valid, i_ldpc_ready,
      output o_dout, o_valid, o_last, o_ldpc_start, o_ldpc_mode
   );
endinterface

// File: rtl/strm2ldpc_seg.sv
// strm2ldpc_seg: FIFO-buffered stream segmenter releasing segmax+1 words per start to the LDPC encoder
module strm2ldpc_seg #(
   parameter int DATA_WIDTH = 8,
   parameter int LOG2_DEPTH = 4,
   parameter int SEG_W      = 18,
   parameter int MODE_W     = 2,
   parameter int DONE_DLY   = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   strm2ldpc_seg_if.slave           bus,
   input  logic                     i_st_start,
   input  logic [SEG_W+MODE_W-1:0]  i_st_opt,
   input  logic                     i_abort,
   input  logic                     i_clr_stat,
   output logic                     o_st_done,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic [LOG2_DEPTH:0]      o_maxdcnt
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wptr, rptr;
   logic [LOG2_DEPTH:0]   cnt;
   logic [SEG_W-1:0]      stcnt, segmax;
   logic [DONE_DLY-1:0]   dpipe;
   logic                  pop, push, drop, fin;

   // Handshake decode; abort overrides every other action in its cycle, and a
   // final pop that coincides with a restart belongs to the abandoned segment
   always_comb begin
      pop  = o_busy & (cnt != '0) & bus.i_ldpc_ready & ~i_abort;
      push = bus.i_valid & ~i_abort & ((cnt != FULL) | pop);
      drop = bus.i_valid & ~i_abort & ~push;
      fin  = pop & (stcnt == segmax) & ~i_st_start;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (i_abort) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         cnt <= cnt + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
      end
   end

   // FIFO storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.i_din;
   end

   // Segment control: start loads length/mode, pops count up to segmax
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_busy           <= 1'b0;
         stcnt            <= '0;
         segmax           <= '0;
         bus.o_ldpc_mode  <= '0;
         bus.o_ldpc_start <= 1'b0;
      end else begin
         bus.o_ldpc_start <= i_st_start & ~i_abort;
         if (i_abort) begin
            o_busy <= 1'b0;
            stcnt  <= '0;
         end else if (i_st_start) begin
            o_busy          <= 1'b1;
            stcnt           <= '0;
            segmax          <= i_st_opt[SEG_W+MODE_W-1:MODE_W];
            bus.o_ldpc_mode <= i_st_opt[MODE_W-1:0];
         end else if (pop) begin
            o_busy <= ~fin;
            stcnt  <= fin ? '0 : stcnt + 1'b1;
         end
      end
   end

   // Registered output word with valid/last strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.o_dout  <= '0;
         bus.o_valid <= 1'b0;
         bus.o_last  <= 1'b0;
      end else begin
         bus.o_valid <= pop;
         bus.o_last  <= fin;
         if (pop) bus.o_dout <= mem[rptr];
      end
   end

   // Done delay line: final pop at P yields o_st_done at P+1+DONE_DLY
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dpipe     <= '0;
         o_st_done <= 1'b0;
      end else if (i_abort) begin
         dpipe     <= '0;
         o_st_done <= 1'b0;
      end else begin
         dpipe     <= DONE_DLY'({dpipe, fin});
         o_st_done <= dpipe[DONE_DLY-1];
      end
   end

   // Debug status: sticky overflow and peak occupancy, clear has priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_overflow <= 1'b0;
         o_maxdcnt  <= '0;
      end else if (i_clr_stat) begin
         o_overflow <= 1'b0;
         o_maxdcnt  <= '0;
      end else begin
         if (drop) o_overflow <= 1'b1;
         if (cnt > o_maxdcnt) o_maxdcnt <= cnt;
      end
   end
endmodule
